freq_scaler_prog: RTL and testbench
===================================

FREQ_SCALER_PROG -- requirements
Module: freq_scaler_prog

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, the width of the half-period divisor.
REQ-003 SHALL have parameter RST_HALF, default 8, the reset half-period per channel; 50 MHz / (2*8) = 3.125 MHz.
REQ-004 clk_50M  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 en  input  NCH  per-channel run enable.
REQ-007 sync  input  1  global phase-realign strobe, one cycle.
REQ-008 wr_en  input  1  divisor write strobe.
REQ-009 wr_ch  input  4  target channel index.
REQ-010 wr_half  input  DIV_W  new half-period in input cycles.
REQ-011 wr_ack  output  1  registered, write accepted.
REQ-012 wr_err  output  1  registered, write rejected.
REQ-013 clk_out  output  NCH  divided clocks, registered.
REQ-014 tick  output  NCH  one-cycle pulse coincident with each clk_out 0->1 transition.
REQ-015 pend  output  NCH  per channel, a divisor update is pending.

Function
REQ-016 Each channel SHALL hold half (active divisor), nxt (pending divisor), cnt (DIV_W-bit counter) and clk_out.
REQ-017 Enabled channel, no sync: if cnt == half-1 then cnt<=0, clk_out<=~clk_out, else cnt<=cnt+1; output period = 2*half cycles, 50% duty.
REQ-018 With half=8 after reset and en=1, the first clk_out rise SHALL be registered on the 8th enabled edge and toggles SHALL follow every 8 edges.
REQ-019 tick[i] SHALL be 1 in exactly the cycles where clk_out[i] is 1 and was 0 the cycle before.
REQ-020 en[i]=0 SHALL clear cnt and clk_out of channel i on the next edge and suppress tick; re-enabling restarts from cnt=0.
REQ-021 A write with wr_ch<NCH and wr_half!=0 SHALL store nxt, set pend, and pulse wr_ack on the next cycle.
REQ-022 A write with wr_ch>=NCH or wr_half==0 SHALL change no state and pulse wr_err on the next cycle.
REQ-023 A pending divisor SHALL be applied (half<=nxt, pend cleared) only at a toggle boundary (cnt == half-1), while the channel is disabled, or on sync: glitch-free, no truncated half-period.
REQ-024 A second write to a pending channel SHALL overwrite nxt; only the last value is applied.
REQ-025 A write and an apply in the same cycle on one channel: the old nxt is applied and the new write stays pending (pend remains 1).
REQ-026 sync=1 SHALL, on the next edge, clear cnt and clk_out on all channels and apply all pending divisors; a same-cycle write becomes pending after the sync.
REQ-027 Counters SHALL never exceed half-1; wrap is by compare, not overflow; half=1 gives divide-by-2.

Reset
REQ-028 rst_n=0 at an edge SHALL set half=nxt=RST_HALF, cnt=0, clk_out=0, tick=0, pend=0, wr_ack=0, wr_err=0 on all channels.
REQ-029 Reset SHALL take priority over sync, en and wr_en; reset mid-period abandons that period with no tick.

Structure
REQ-030 Shared package freq_scaling_pkg SHALL hold the default DIV_W, RST_HALF, the channel-index width, and the 50 MHz input frequency constant.
REQ-031 One sub-module, freq_div_channel, SHALL implement REQ-016..020, 023 and 027 for a single channel; the top SHALL instantiate it NCH times and hold the write decode, ack/err and sync fan-out.

Verification
REQ-032 Reset, en=4'hF, run 64 cycles -> every clk_out toggles every 8 cycles (rises at cycles 8, 24, 40, 56); 4 ticks per channel.
REQ-033 Write ch1 half=3 mid-period -> wr_ack next cycle, pend[1]=1 until the current 8-cycle half completes, then period 6; no output pulse shorter than 3 cycles.
REQ-034 Write ch5 (NCH=4) and write half=0 to ch0 -> wr_err pulses, no state or pend change.
REQ-035 Channels at half 8/3/5/2, pulse sync -> all clk_out=0 and cnt=0 next cycle; the first rises land 8/3/5/2 cycles later.
REQ-036 Drop en[2] for 1 cycle, then assert rst_n=0 mid-period on all channels -> the channel clears, restarts from cnt=0, reset returns all to RST_HALF, no spurious tick.

Source files
------------

// File: rtl/freq_scaling_pkg.sv
// Shared constants for the programmable clock divider block.
package freq_scaling_pkg;
  localparam int DEF_DIV_W    = 8;
  localparam int DEF_RST_HALF = 8;           // 50 MHz / (2*8) = 3.125 MHz
  localparam int CH_W         = 4;           // width of the channel index on the write port
  localparam int F_IN_HZ      = 50_000_000;  // clk_50M frequency
endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: half-period counter, output toggle, tick on the rising
// edge of clk_out, and a pending divisor that only takes effect where it cannot
// shorten a half-period (wrap point, while disabled, or on sync).
module freq_div_channel
  import freq_scaling_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int RST_HALF = DEF_RST_HALF
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] HALF_INIT = DIV_W'(RST_HALF);

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] nxt;
  logic [DIV_W-1:0] cnt;
  logic             at_wrap;
  logic             apply;

  // half is never zero (reset value and writes exclude it), so half-1 cannot underflow.
  assign at_wrap = (cnt == (half - ONE));
  assign apply   = pend && (sync || !en || at_wrap);

  // Counter, output level, tick and divisor bookkeeping; a write in the same
  // cycle as an apply wins the pend flag so the newer value is not lost.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      half    <= HALF_INIT;
      nxt     <= HALF_INIT;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (at_wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end

      if (apply) half <= nxt;

      if (wr) begin
        nxt  <= wr_half;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_scaler_prog.sv
// Multi-channel programmable clock divider: write decode with ack/err,
// sync fan-out, and NCH independent divider channels.
module freq_scaler_prog
  import freq_scaling_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int RST_HALF = DEF_RST_HALF
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_half,
  output logic             wr_ack,
  output logic             wr_err,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  logic           wr_ok;
  logic [NCH-1:0] wr_sel;

  // Extra bit on the compare so NCH=16 still fits.
  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NCH)) && (wr_half != '0);

  // One-hot load strobe to the addressed channel.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ok && (wr_ch == CH_W'(i))) wr_sel[i] = 1'b1;
    end
  end

  // Registered accept/reject response to each write strobe.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    freq_div_channel #(
      .DIV_W    (DIV_W),
      .RST_HALF (RST_HALF)
    ) u_ch (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr_sel[g]),
      .wr_half (wr_half),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_freq_scaler_prog.sv
// Self-checking bench for freq_scaler_prog (NCH=4, DIV_W=8, RST_HALF=8).
module tb_freq_scaler_prog;
  localparam int NCH = 4;

  logic           clk_50M = 1'b0;
  logic           rst_n   = 1'b0;
  logic [NCH-1:0] en      = '0;
  logic           sync    = 1'b0;
  logic           wr_en   = 1'b0;
  logic [3:0]     wr_ch   = '0;
  logic [7:0]     wr_half = '0;
  logic           wr_ack, wr_err;
  logic [NCH-1:0] clk_out, tick, pend;

  freq_scaler_prog dut (
    .clk_50M (clk_50M), .rst_n (rst_n), .en (en), .sync (sync),
    .wr_en (wr_en), .wr_ch (wr_ch), .wr_half (wr_half),
    .wr_ack (wr_ack), .wr_err (wr_err),
    .clk_out (clk_out), .tick (tick), .pend (pend)
  );

  always #10 clk_50M = ~clk_50M;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is an "epoch" of constant divisor that began
  // at a known level; the level is start level xor parity of whole half-periods
  // elapsed. Disable/sync/reset restart the epoch low; an applied divisor
  // starts a new epoch at the boundary where it took effect.
  int m_half [NCH];
  int m_nxt  [NCH];
  int m_el   [NCH];
  bit m_lvl0 [NCH];
  bit m_tick [NCH];
  bit m_pend [NCH];
  bit m_ack, m_err;

  function automatic bit m_clk(int c);
    return m_lvl0[c] ^ bit'((m_el[c] / m_half[c]) % 2);
  endfunction

  task automatic model_step(bit r, logic [3:0] e, bit s, bit we, int ch, int hv);
    bit ok;
    if (!r) begin
      for (int c = 0; c < NCH; c++) begin
        m_half[c] = 8; m_nxt[c] = 8; m_el[c] = 0;
        m_lvl0[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end
      m_ack = 0; m_err = 0;
      return;
    end
    ok = we && (ch < NCH) && (hv != 0);
    for (int c = 0; c < NCH; c++) begin
      bit app = 0;
      if (s || !e[c]) begin
        app = m_pend[c];
        if (app) m_half[c] = m_nxt[c];
        m_el[c] = 0; m_lvl0[c] = 0; m_tick[c] = 0;
      end else begin
        bit lvl;
        bit toggled;
        m_el[c]++;
        toggled = (m_el[c] % m_half[c]) == 0;
        lvl = m_clk(c);
        m_tick[c] = toggled && lvl;
        if (toggled && m_pend[c]) begin
          app = 1;
          m_half[c] = m_nxt[c];
          m_lvl0[c] = lvl;
          m_el[c] = 0;
        end
      end
      if (ok && ch == c) begin
        m_nxt[c] = hv; m_pend[c] = 1;
      end else if (app) begin
        m_pend[c] = 0;
      end
    end
    m_ack = ok;
    m_err = we && !ok;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < NCH; c++) begin
      e_clk[c] = m_clk(c); e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
    end
    check("model_clk_out", 32'(clk_out), 32'(e_clk));
    check("model_tick",    32'(tick),    32'(e_tick));
    check("model_pend",    32'(pend),    32'(e_pend));
    check("model_wr_ack",  32'(wr_ack),  32'(m_ack));
    check("model_wr_err",  32'(wr_err),  32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after it.
  task automatic step(bit r, logic [3:0] e, bit s, bit we, logic [3:0] ch, logic [7:0] hv);
    rst_n = r; en = e; sync = s; wr_en = we; wr_ch = ch; wr_half = hv;
    @(posedge clk_50M);
    model_step(r, e, s, we, int'(ch), int'(hv));
    #1;
    check_model();
  endtask

  task automatic do_reset();
    step(0, 4'h0, 0, 0, 4'd0, 8'd0);
    step(0, 4'h0, 0, 0, 4'd0, 8'd0);
  endtask

  typedef struct {
    logic       we;
    logic [3:0] ch;
    logic [7:0] hv;
    logic       ack;
    logic       err;
    logic [3:0] pnd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int ticks [NCH];
    int first [NCH];
    int exp_first [NCH];

    tbl[0] = '{1'b1, 4'd1,  8'd3,   1'b1, 1'b0, 4'b0010};
    tbl[1] = '{1'b1, 4'd5,  8'd3,   1'b0, 1'b1, 4'b0010};
    tbl[2] = '{1'b1, 4'd0,  8'd0,   1'b0, 1'b1, 4'b0010};
    tbl[3] = '{1'b1, 4'd3,  8'd200, 1'b1, 1'b0, 4'b1010};
    tbl[4] = '{1'b0, 4'd2,  8'd4,   1'b0, 1'b0, 4'b1010};
    tbl[5] = '{1'b1, 4'd15, 8'd1,   1'b0, 1'b1, 4'b1010};

    // Reset state
    do_reset();
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick",    32'(tick),    0);
    check("rst_pend",    32'(pend),    0);
    check("rst_ack_err", 32'({wr_ack, wr_err}), 0);

    // Write decode table (channels running at half=8, no wrap within 6 edges)
    for (int i = 0; i < 6; i++) begin
      step(1, 4'hF, 0, tbl[i].we, tbl[i].ch, tbl[i].hv);
      check($sformatf("tbl%0d_ack", i),  32'(wr_ack), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_err", i),  32'(wr_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_pend", i), 32'(pend),   32'(tbl[i].pnd));
    end

    // Free run at reset divisor: rises on edges 8, 24, 40, 56
    do_reset();
    for (int c = 0; c < NCH; c++) ticks[c] = 0;
    for (int k = 1; k <= 64; k++) begin
      step(1, 4'hF, 0, 0, 4'd0, 8'd0);
      check($sformatf("run_tick_k%0d", k), 32'(tick), (k % 16 == 8) ? 32'hF : 32'h0);
      for (int c = 0; c < NCH; c++) if (tick[c]) ticks[c]++;
    end
    for (int c = 0; c < NCH; c++) check($sformatf("run_nticks_ch%0d", c), 32'(ticks[c]), 4);

    // Mid-period write to ch1: applies at the edge-8 boundary, then period 6
    do_reset();
    for (int k = 1; k <= 3; k++) step(1, 4'hF, 0, 0, 4'd0, 8'd0);
    step(1, 4'hF, 0, 1, 4'd1, 8'd3);
    check("mid_ack", 32'(wr_ack), 1);
    for (int k = 5; k <= 19; k++) begin
      step(1, 4'hF, 0, 0, 4'd0, 8'd0);
      check($sformatf("mid_pend_k%0d", k), 32'(pend[1]), (k < 8) ? 1 : 0);
      if (k >= 8)
        check($sformatf("mid_clk_k%0d", k), 32'(clk_out[1]), (((k - 8) / 3) % 2 == 0) ? 1 : 0);
    end

    // Sync with halves 8/3/5/2 and a same-cycle write to ch0
    do_reset();
    step(1, 4'hF, 0, 1, 4'd1, 8'd3);
    step(1, 4'hF, 0, 1, 4'd2, 8'd5);
    step(1, 4'hF, 0, 1, 4'd3, 8'd2);
    step(1, 4'hF, 1, 1, 4'd0, 8'd8);
    check("sync_clk_out", 32'(clk_out), 0);
    check("sync_pend",    32'(pend), 32'h1);
    exp_first[0] = 8; exp_first[1] = 3; exp_first[2] = 5; exp_first[3] = 2;
    for (int c = 0; c < NCH; c++) first[c] = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1, 4'hF, 0, 0, 4'd0, 8'd0);
      for (int c = 0; c < NCH; c++) if (tick[c] && first[c] == 0) first[c] = k;
    end
    for (int c = 0; c < NCH; c++)
      check($sformatf("sync_first_rise_ch%0d", c), 32'(first[c]), 32'(exp_first[c]));

    // Drop en[2] for a cycle, then reset mid-period
    do_reset();
    for (int k = 1; k <= 9; k++) step(1, 4'hF, 0, 0, 4'd0, 8'd0);
    step(1, 4'hB, 0, 1, 4'd1, 8'd3);
    check("dis_clk2",  32'(clk_out[2]), 0);
    check("dis_tick2", 32'(tick[2]), 0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 4'hF, 0, 0, 4'd0, 8'd0);
      check($sformatf("reen_tick2_k%0d", k), 32'(tick[2]), (k == 8) ? 1 : 0);
    end
    step(1, 4'hF, 0, 0, 4'd0, 8'd0);
    step(0, 4'hF, 1, 1, 4'd2, 8'd4);
    check("midrst_clk_out", 32'(clk_out), 0);
    check("midrst_tick",    32'(tick), 0);
    check("midrst_pend",    32'(pend), 0);
    for (int k = 1; k <= 8; k++) begin
      step(1, 4'hF, 0, 0, 4'd0, 8'd0);
      check($sformatf("postrst_tick_k%0d", k), 32'(tick), (k == 8) ? 32'hF : 32'h0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] e;
      bit r, s, we;
      e = en;
      if ($urandom_range(15) == 0) e[$urandom_range(3)] = ~e[$urandom_range(3)];
      if ($urandom_range(7) == 0) e = 4'hF;
      r  = ($urandom_range(299) != 0);
      s  = ($urandom_range(40) == 0);
      we = ($urandom_range(3) == 0);
      step(r, e, s, we, 4'($urandom_range(7)), 8'($urandom_range(12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
